mips32_mem_arb: RTL
===================

# mips32_mem_arb

Single-port memory arbiter for the MIPS32 core. It shares one unified single-ported instruction/data memory between the instruction-fetch requester (IF) and the load/store requester (DM). It grants one access at a time, holds the memory for the configured read latency, and routes read data back to the owning port. It sits between the IF/MEM pipeline stages and the memory macro; the core stalls a stage whose request is pending without a grant.

## Interface
- AW, 9: word address width (512 words)
- DW, 32: data width
- MEM_LAT, 2: memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7
- STARVE_MAX, 3: consecutive DM grants that may pass while IF waits (fair mode only)

Ports:
- clk_1  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- halt  in  1  core halted; blocks new grants
- if_req  in  1  IF read request, held until if_gnt
- if_addr  in  AW  IF word address
- if_gnt  out  1  one-cycle grant pulse to IF
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DW  read data to IF
- dm_req  in  1  DM request, held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  DM word address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  one-cycle grant pulse to DM
- dm_rvalid  out  1  one-cycle pulse; dm_rdata valid (loads only)
- dm_rdata  out  DW  read data to DM
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - GRANT: one cycle; mem_en=1, selected *_gnt=1.
  - WAIT: MEM_LAT-1 cycles; skipped when MEM_LAT=1.
  - RESP: one cycle; owner's *_rvalid=1.
- IDLE -> GRANT when (if_req | dm_req) & !halt. The winning port's address, we and wdata are registered into mem_addr/mem_we/mem_wdata, and an owner bit is recorded.
- GRANT, store -> IDLE. GRANT, read -> WAIT (or RESP if MEM_LAT=1).
- WAIT -> RESP when the latency counter expires.
- RESP arbitrates like IDLE and may go directly to GRANT. The owner's req is ignored in RESP and in GRANT.
- Priority: DM wins a simultaneous request (older instruction), except in fair mode (see Configuration).
- *_rdata are combinational pass-throughs of mem_rdata. They are meaningful only while the matching *_rvalid is high.
- A requester must keep req/addr/we/wdata stable until its gnt. It drops or changes req the cycle after gnt.
- halt blocks transitions into GRANT only; an access already granted completes, including RESP.
- Reset mid-access: everything returns to reset values immediately; an in-flight response is discarded (no rvalid).
- Reset values: all outputs 0, state IDLE, latency counter 0, starve counter 0, owner bit 0.

## Timing
- Outputs mem_en, mem_we, mem_addr, mem_wdata, *_gnt, *_rvalid and busy are registered or decoded from state registers. No combinational path from req to gnt.
- Request sampled at cycle N in IDLE/RESP -> gnt and mem_en at N+1 -> rvalid at N+1+MEM_LAT.
- Read occupancy is MEM_LAT+1 cycles. Back-to-back reads: one grant every MEM_LAT+1 cycles.
- Store occupancy is 1 cycle plus 1 IDLE cycle. Back-to-back stores: one grant every 2 cycles.
- Minimum request-to-gnt latency is 1 cycle.

## Configuration
- MIPS32_ARB_FAIR_EN defined:
  - A starve counter (width clog2(STARVE_MAX+1)) increments, saturating, on each DM grant while if_req is high.
  - It clears on any IF grant.
  - When the counter equals STARVE_MAX and both request, IF wins.
- MIPS32_ARB_FAIR_EN undefined: strict DM priority; the counter logic is absent. IF may starve under continuous DM traffic.

## Test plan
- Single IF read, MEM_LAT=2, if_addr=0x010, memory word 0x2000_000A: if_gnt at N+1, mem_en=1/mem_we=0/mem_addr=0x010 at N+1, if_rvalid=1 with if_rdata=0x2000_000A at N+3, busy low at N+4.
- DM store dm_addr=0x005, dm_wdata=0xDEAD_BEEF: mem_en=mem_we=1 for exactly one cycle at N+1, no dm_rvalid; a following load of 0x005 returns 0xDEAD_BEEF.
- if_req and dm_req both high at N: dm_gnt at N+1, if_gnt at N+4 (MEM_LAT=2, DM load), never both gnts in one cycle.
- Fair mode, STARVE_MAX=3, dm_req and if_req held continuously: grant sequence DM,DM,DM,IF,DM,DM,DM,IF; with macro undefined: DM only, no if_gnt in 20 grants.
- halt asserted in the WAIT cycle of an IF read: if_rvalid still pulses; pending dm_req gets no dm_gnt until halt drops, then dm_gnt one cycle later.
- rst pulled low in WAIT: all outputs 0 asynchronously, no rvalid after release, first grant after release occurs 1 cycle after a sampled request.

Source files
------------

// File: rtl/mips32_mem_arb.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// One access at a time; reads hold the memory for MEM_LAT cycles and the data is
// steered back to the port that owns the access.
// Optional feature: define MIPS32_ARB_FAIR_EN to add the IF anti-starvation counter.
//
// state | meaning
// IDLE  | arbitrate between pending requests
// GRANT | memory strobe issued, grant pulse to the winner
// WAIT  | read latency in progress (absent when MEM_LAT = 1)
// RESP  | read data valid for the owner; arbitrates for the next access
module mips32_mem_arb #(
    parameter int AW         = 9,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk_1,
    input  logic          rst,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

    // WAIT lasts MEM_LAT-1 cycles: down-counter loaded with MEM_LAT-2, exits at zero.
    localparam logic [2:0] LAT_LOAD = 3'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    state_t        state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic          owner_q;       // 1 = DM owns the current access
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic arb_ok, req_if_e, req_dm_e, take, if_turn, pick_dm;

`ifdef MIPS32_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q;

    // Count DM grants that bypass a waiting IF; any IF grant restarts the count.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (take) begin
            if (!pick_dm)
                starve_q <= '0;
            else if (if_req && (starve_q != SW'(STARVE_MAX)))
                starve_q <= starve_q + 1'b1;
        end
    end

    assign if_turn = req_if_e && req_dm_e && (starve_q == SW'(STARVE_MAX));
`else
    assign if_turn = 1'b0;
`endif

    // In RESP the owner's request line belongs to the access just finished, so it is masked.
    assign arb_ok   = (state_q == IDLE) || (state_q == RESP);
    assign req_if_e = if_req && !((state_q == RESP) && !owner_q);
    assign req_dm_e = dm_req && !((state_q == RESP) && owner_q);
    assign take     = arb_ok && !halt && (req_if_e || req_dm_e);
    assign pick_dm  = req_dm_e && !if_turn;

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (take) state_d = GRANT;
            end
            GRANT: begin
                if (we_q) begin
                    state_d = IDLE;
                end else if (MEM_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    lat_d   = LAT_LOAD;
                end
            end
            WAIT: begin
                if (lat_q == 3'd0) state_d = RESP;
                else               lat_d   = lat_q - 3'd1;
            end
            RESP: begin
                state_d = take ? GRANT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and latched access of the winning port.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (take) begin
                owner_q <= pick_dm;
                we_q    <= pick_dm && dm_we;
                addr_q  <= pick_dm ? dm_addr : if_addr;
                wdata_q <= pick_dm ? dm_wdata : '0;
            end
        end
    end

    assign mem_en    = (state_q == GRANT);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = mem_en && !owner_q;
    assign dm_gnt    = mem_en && owner_q;
    assign if_rvalid = (state_q == RESP) && !owner_q;
    assign dm_rvalid = (state_q == RESP) && owner_q;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign busy      = (state_q != IDLE);

endmodule
